// File: rtl/cabac_bin_decoder.sv
// CABAC arithmetic decoding engine: regular, bypass and terminate bins.
// Owns the 9-bit range/offset pair and a 16-bit byte-fed bit buffer.
// Optional feature macro: CABAC_DEC_BIN_CNT_EN adds a 32-bit decoded-bin counter
// output (bin_cnt_o).
module cabac_bin_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   input  logic        bin_valid_i,
   output logic        bin_ready_o,
   input  logic [1:0]  bin_mode_i,
   input  logic [5:0]  pstate_i,
   input  logic        valmps_i,
   output logic        bin_valid_o,
   output logic        bin_o,
   output logic [5:0]  pstate_o,
   output logic        valmps_o
`ifdef CABAC_DEC_BIN_CNT_EN
   ,
   output logic [31:0] bin_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

   state_t      state_reg;
   logic [8:0]  range_reg, offset_reg;
   logic [15:0] buf_reg;          // buf_reg[15] is the next bit to consume
   logic [4:0]  cnt_reg;
   logic        bin_valid_reg, bin_reg, valmps_reg;
   logic [5:0]  pstate_reg;

   logic        byte_acc, bin_acc, init_exit;
   logic [15:0] merged_buf;
   logic [4:0]  merged_cnt;
   logic [3:0]  consume;
   logic [37:0] ctx;
   logic [8:0]  rlps, rmps, term_range, pre_range, pre_off;
   logic [9:0]  byp_off;
   logic        renorm_en;
   logic [2:0]  sh;
   logic        dec_bin, dec_valmps, dec_end;
   logic [5:0]  dec_pstate;
   logic [8:0]  dec_range, dec_off;
   logic [3:0]  dec_used;

   // Row = {transIdxLps, rLPS for q = 0, 1, 2, 3}
   function automatic logic [37:0] ctx_row(input logic [5:0] s);
      logic [37:0] r;
      case (s)
         6'd0:  r = {6'd0,  8'd128, 8'd176, 8'd208, 8'd240};
         6'd1:  r = {6'd0,  8'd128, 8'd167, 8'd197, 8'd227};
         6'd2:  r = {6'd1,  8'd128, 8'd158, 8'd187, 8'd216};
         6'd3:  r = {6'd2,  8'd123, 8'd150, 8'd178, 8'd205};
         6'd4:  r = {6'd2,  8'd116, 8'd142, 8'd169, 8'd195};
         6'd5:  r = {6'd4,  8'd111, 8'd135, 8'd160, 8'd185};
         6'd6:  r = {6'd4,  8'd105, 8'd128, 8'd152, 8'd175};
         6'd7:  r = {6'd5,  8'd100, 8'd122, 8'd144, 8'd166};
         6'd8:  r = {6'd6,  8'd95,  8'd116, 8'd137, 8'd158};
         6'd9:  r = {6'd7,  8'd90,  8'd110, 8'd130, 8'd150};
         6'd10: r = {6'd8,  8'd85,  8'd104, 8'd123, 8'd142};
         6'd11: r = {6'd9,  8'd81,  8'd99,  8'd117, 8'd135};
         6'd12: r = {6'd9,  8'd77,  8'd94,  8'd111, 8'd128};
         6'd13: r = {6'd11, 8'd73,  8'd89,  8'd105, 8'd122};
         6'd14: r = {6'd11, 8'd69,  8'd85,  8'd100, 8'd116};
         6'd15: r = {6'd12, 8'd66,  8'd80,  8'd95,  8'd110};
         6'd16: r = {6'd13, 8'd62,  8'd76,  8'd90,  8'd104};
         6'd17: r = {6'd13, 8'd59,  8'd72,  8'd86,  8'd99};
         6'd18: r = {6'd15, 8'd56,  8'd69,  8'd81,  8'd94};
         6'd19: r = {6'd15, 8'd53,  8'd65,  8'd77,  8'd89};
         6'd20: r = {6'd16, 8'd51,  8'd62,  8'd73,  8'd85};
         6'd21: r = {6'd16, 8'd48,  8'd59,  8'd69,  8'd80};
         6'd22: r = {6'd18, 8'd46,  8'd56,  8'd66,  8'd76};
         6'd23: r = {6'd18, 8'd43,  8'd53,  8'd63,  8'd72};
         6'd24: r = {6'd19, 8'd41,  8'd50,  8'd59,  8'd69};
         6'd25: r = {6'd19, 8'd39,  8'd48,  8'd56,  8'd65};
         6'd26: r = {6'd21, 8'd37,  8'd45,  8'd54,  8'd62};
         6'd27: r = {6'd21, 8'd35,  8'd43,  8'd51,  8'd59};
         6'd28: r = {6'd22, 8'd33,  8'd41,  8'd48,  8'd56};
         6'd29: r = {6'd22, 8'd32,  8'd39,  8'd46,  8'd53};
         6'd30: r = {6'd23, 8'd30,  8'd37,  8'd43,  8'd50};
         6'd31: r = {6'd24, 8'd29,  8'd35,  8'd41,  8'd48};
         6'd32: r = {6'd24, 8'd27,  8'd33,  8'd39,  8'd45};
         6'd33: r = {6'd25, 8'd26,  8'd31,  8'd37,  8'd43};
         6'd34: r = {6'd26, 8'd24,  8'd30,  8'd35,  8'd41};
         6'd35: r = {6'd26, 8'd23,  8'd28,  8'd33,  8'd39};
         6'd36: r = {6'd27, 8'd22,  8'd27,  8'd32,  8'd37};
         6'd37: r = {6'd27, 8'd21,  8'd26,  8'd30,  8'd35};
         6'd38: r = {6'd28, 8'd20,  8'd24,  8'd29,  8'd33};
         6'd39: r = {6'd29, 8'd19,  8'd23,  8'd27,  8'd31};
         6'd40: r = {6'd29, 8'd18,  8'd22,  8'd26,  8'd30};
         6'd41: r = {6'd30, 8'd17,  8'd21,  8'd25,  8'd28};
         6'd42: r = {6'd30, 8'd16,  8'd20,  8'd23,  8'd27};
         6'd43: r = {6'd30, 8'd15,  8'd19,  8'd22,  8'd25};
         6'd44: r = {6'd31, 8'd14,  8'd18,  8'd21,  8'd24};
         6'd45: r = {6'd32, 8'd14,  8'd17,  8'd20,  8'd23};
         6'd46: r = {6'd32, 8'd13,  8'd16,  8'd19,  8'd22};
         6'd47: r = {6'd33, 8'd12,  8'd15,  8'd18,  8'd21};
         6'd48: r = {6'd33, 8'd12,  8'd14,  8'd17,  8'd20};
         6'd49: r = {6'd33, 8'd11,  8'd14,  8'd16,  8'd19};
         6'd50: r = {6'd34, 8'd11,  8'd13,  8'd15,  8'd18};
         6'd51: r = {6'd34, 8'd10,  8'd12,  8'd15,  8'd17};
         6'd52: r = {6'd35, 8'd10,  8'd12,  8'd14,  8'd16};
         6'd53: r = {6'd35, 8'd9,   8'd11,  8'd13,  8'd15};
         6'd54: r = {6'd35, 8'd9,   8'd11,  8'd12,  8'd14};
         6'd55: r = {6'd36, 8'd8,   8'd10,  8'd12,  8'd14};
         6'd56: r = {6'd36, 8'd8,   8'd9,   8'd11,  8'd13};
         6'd57: r = {6'd36, 8'd7,   8'd9,   8'd11,  8'd12};
         6'd58: r = {6'd37, 8'd7,   8'd9,   8'd10,  8'd12};
         6'd59: r = {6'd37, 8'd7,   8'd8,   8'd10,  8'd11};
         6'd60: r = {6'd37, 8'd6,   8'd8,   8'd9,   8'd11};
         6'd61: r = {6'd38, 8'd6,   8'd7,   8'd9,   8'd10};
         6'd62: r = {6'd38, 8'd6,   8'd7,   8'd8,   8'd9};
         default: r = {6'd63, 8'd2, 8'd2,   8'd2,   8'd2};
      endcase
      return r;
   endfunction

   assign byte_ready_o = (cnt_reg <= 5'd8) && !start_i;
   assign bin_ready_o  = (state_reg == RUN) && (cnt_reg >= 5'd7) && !start_i;
   assign byte_acc     = byte_valid_i && byte_ready_o;
   assign bin_acc      = bin_valid_i && bin_ready_o;
   assign bin_valid_o  = bin_valid_reg;
   assign bin_o        = bin_reg;
   assign pstate_o     = pstate_reg;
   assign valmps_o     = valmps_reg;

   // Append an accepted byte behind the buffered bits; consumers read from this merged view
   always_comb begin
      merged_buf = buf_reg;
      merged_cnt = cnt_reg;
      if (byte_acc) begin
         merged_buf = buf_reg | ({byte_i, 8'h00} >> cnt_reg);
         merged_cnt = cnt_reg + 5'd8;
      end
      init_exit = (state_reg == INIT) && (merged_cnt >= 5'd9);
      consume   = init_exit ? 4'd9 : (bin_acc ? dec_used : 4'd0);
   end

   // Bin decode: interval subdivision, context transition and renormalization
   always_comb begin
      ctx        = ctx_row(pstate_i);
      case (range_reg[7:6])
         2'd0:    rlps = {1'b0, ctx[31:24]};
         2'd1:    rlps = {1'b0, ctx[23:16]};
         2'd2:    rlps = {1'b0, ctx[15:8]};
         default: rlps = {1'b0, ctx[7:0]};
      endcase
      rmps       = range_reg - rlps;
      term_range = range_reg - 9'd2;
      // Bypass offset needs a tenth bit: offset may exceed 255 before doubling
      byp_off    = {offset_reg, merged_buf[15]};
      dec_bin    = 1'b0;
      dec_pstate = pstate_i;
      dec_valmps = valmps_i;
      dec_end    = 1'b0;
      pre_range  = range_reg;
      pre_off    = offset_reg;
      renorm_en  = 1'b1;
      dec_range  = range_reg;
      dec_off    = offset_reg;
      dec_used   = 4'd0;
      sh         = 3'd0;
      case (bin_mode_i)
         2'd0: begin
            if (offset_reg >= rmps) begin
               dec_bin    = !valmps_i;
               pre_off    = offset_reg - rmps;
               pre_range  = rlps;
               dec_pstate = ctx[37:32];
               if (pstate_i == 6'd0)
                  dec_valmps = !valmps_i;
            end else begin
               dec_bin    = valmps_i;
               pre_range  = rmps;
               dec_pstate = (pstate_i < 6'd62) ? pstate_i + 6'd1 : pstate_i;
            end
         end
         2'd2: begin
            pre_range = term_range;
            if (offset_reg >= term_range) begin
               dec_bin   = 1'b1;
               dec_end   = 1'b1;
               renorm_en = 1'b0;
            end
         end
         default: begin
            renorm_en = 1'b0;
            dec_used  = 4'd1;
            if (byp_off >= {1'b0, range_reg}) begin
               dec_bin = 1'b1;
               dec_off = 9'(byp_off - {1'b0, range_reg});
            end else begin
               dec_off = byp_off[8:0];
            end
         end
      endcase
      if (renorm_en) begin
         for (int i = 1; i <= 6; i++)
            if ((pre_range >> (9 - i)) == 9'd0)
               sh = 3'(i);
         dec_range = pre_range << sh;
         dec_off   = 9'(({pre_off, merged_buf[15:9]} << sh) >> 7);
         dec_used  = {1'b0, sh};
      end else if (bin_mode_i == 2'd2) begin
         dec_range = pre_range;
      end
   end

   // Engine FSM, arithmetic registers, bit buffer and registered bin outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         range_reg     <= 9'd510;
         offset_reg    <= 9'd0;
         buf_reg       <= 16'h0000;
         cnt_reg       <= 5'd0;
         bin_valid_reg <= 1'b0;
         bin_reg       <= 1'b0;
         pstate_reg    <= 6'd0;
         valmps_reg    <= 1'b0;
      end else if (start_i) begin
         state_reg     <= INIT;
         buf_reg       <= 16'h0000;
         cnt_reg       <= 5'd0;
         bin_valid_reg <= 1'b0;
      end else begin
         bin_valid_reg <= bin_acc;
         buf_reg       <= merged_buf << consume;
         cnt_reg       <= merged_cnt - {1'b0, consume};
         if (bin_acc) begin
            bin_reg    <= dec_bin;
            pstate_reg <= dec_pstate;
            valmps_reg <= dec_valmps;
            range_reg  <= dec_range;
            offset_reg <= dec_off;
         end
         case (state_reg)
            IDLE: state_reg <= IDLE;
            INIT: begin
               if (init_exit) begin
                  range_reg  <= 9'd510;
                  offset_reg <= merged_buf[15:7];
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               if (bin_acc && dec_end)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CABAC_DEC_BIN_CNT_EN
   logic [31:0] bin_cnt_reg;

   // Decoded-bin counter, advanced at acceptance so it lines up with bin_valid_o
   always_ff @(posedge clk) begin
      if (rst || start_i)
         bin_cnt_reg <= 32'd0;
      else if (bin_acc)
         bin_cnt_reg <= bin_cnt_reg + 32'd1;
   end

   assign bin_cnt_o = bin_cnt_reg;
`endif

endmodule

// File: tb/tb_cabac_bin_decoder.sv
// Directed testbench for cabac_bin_decoder with hand-computed expectations.
// Build with CABAC_DEC_BIN_CNT_EN to also exercise bin_cnt_o.
module tb_cabac_bin_decoder;

   logic        clk = 1'b0;
   logic        rst, start_i, byte_valid_i, bin_valid_i, valmps_i;
   logic [7:0]  byte_i;
   logic [1:0]  bin_mode_i;
   logic [5:0]  pstate_i;
   logic        byte_ready_o, bin_ready_o, bin_valid_o, bin_o, valmps_o;
   logic [5:0]  pstate_o;
`ifdef CABAC_DEC_BIN_CNT_EN
   logic [31:0] bin_cnt_o;
`endif

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   cabac_bin_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .bin_valid_i  (bin_valid_i),
      .bin_ready_o  (bin_ready_o),
      .bin_mode_i   (bin_mode_i),
      .pstate_i     (pstate_i),
      .valmps_i     (valmps_i),
      .bin_valid_o  (bin_valid_o),
      .bin_o        (bin_o),
      .pstate_o     (pstate_o),
      .valmps_o     (valmps_o)
`ifdef CABAC_DEC_BIN_CNT_EN
      ,
      .bin_cnt_o    (bin_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_i       = b;
      byte_valid_i = 1'b1;
      step();
      byte_valid_i = 1'b0;
      $display("byte 0x%02h sent", b);
   endtask

   task automatic bin_req(input logic [1:0] mode, input logic [5:0] ps, input logic mps);
      bin_mode_i  = mode;
      pstate_i    = ps;
      valmps_i    = mps;
      bin_valid_i = 1'b1;
      step();
      bin_valid_i = 1'b0;
      $display("bin mode=%0d ps=%0d mps=%0d -> valid=%0d bin=%0d ps=%0d mps=%0d",
               mode, ps, mps, bin_valid_o, bin_o, pstate_o, valmps_o);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; bin_valid_i = 1'b0;
      byte_i = 8'h00; bin_mode_i = 2'd0; pstate_i = 6'd0; valmps_i = 1'b0;
      step();
      step();
      // Reset state
      check("rst_byte_ready", byte_ready_o, 1);
      check("rst_bin_ready", bin_ready_o, 0);
      check("rst_bin_valid", bin_valid_o, 0);
      check("rst_bin", bin_o, 0);
      check("rst_pstate", pstate_o, 0);
      check("rst_valmps", valmps_o, 0);
      check("rst_range", dut.range_reg, 510);
      check("rst_offset", dut.offset_reg, 0);
      check("rst_count", dut.cnt_reg, 0);
`ifdef CABAC_DEC_BIN_CNT_EN
      check("rst_bin_cnt", bin_cnt_o, 0);
`endif
      rst = 1'b0;

      // Basic regular MPS on a zero stream
      do_start();
      send_byte(8'h00);
      check("init_one_byte_not_ready", bin_ready_o, 0);
      send_byte(8'h00);
      check("init_ready_after_2nd", bin_ready_o, 1);
      check("init_range", dut.range_reg, 510);
      check("init_offset", dut.offset_reg, 0);
      check("init_count", dut.cnt_reg, 7);
      bin_req(2'd0, 6'd0, 1'b0);
      check("mps_valid", bin_valid_o, 1);
      check("mps_bin", bin_o, 0);
      check("mps_pstate", pstate_o, 1);
      check("mps_valmps", valmps_o, 0);
      check("mps_range", dut.range_reg, 270);
      check("mps_count", dut.cnt_reg, 7);
`ifdef CABAC_DEC_BIN_CNT_EN
      check("mps_bin_cnt", bin_cnt_o, 1);
`endif
      step();
      check("valid_is_pulse", bin_valid_o, 0);

      // MPS chain with offset 128, including top-state saturation
      do_start();
      send_byte(8'h40);
      send_byte(8'h00);
      check("chain_offset", dut.offset_reg, 128);
      bin_req(2'd0, 6'd10, 1'b1);
      check("chain1_bin", bin_o, 1);
      check("chain1_pstate", pstate_o, 11);
      check("chain1_range", dut.range_reg, 368);
      bin_req(2'd0, 6'd63, 1'b0);
      check("chain2_bin", bin_o, 0);
      check("chain2_pstate63", pstate_o, 63);
      check("chain2_range", dut.range_reg, 366);
      bin_req(2'd0, 6'd62, 1'b1);
      check("chain3_bin", bin_o, 1);
      check("chain3_pstate62", pstate_o, 62);
      check("chain3_range", dut.range_reg, 359);
      check("chain3_offset", dut.offset_reg, 128);
`ifdef CABAC_DEC_BIN_CNT_EN
      check("chain_bin_cnt", bin_cnt_o, 3);
`endif

      // LPS with MPS flip
      do_start();
      send_byte(8'hFF);
      send_byte(8'h80);
      check("lps_init_offset", dut.offset_reg, 511);
      bin_req(2'd0, 6'd0, 1'b0);
      check("lps_bin", bin_o, 1);
      check("lps_valmps_flip", valmps_o, 1);
      check("lps_pstate", pstate_o, 0);
      check("lps_range", dut.range_reg, 480);
      check("lps_offset", dut.offset_reg, 482);
      check("lps_count", dut.cnt_reg, 6);
      check("lps_stall", bin_ready_o, 0);

      // LPS from state 5 with one-bit renormalization pulling in a 1
      do_start();
      send_byte(8'hFF);
      send_byte(8'hFF);
      bin_req(2'd0, 6'd5, 1'b1);
      check("lps5_bin", bin_o, 0);
      check("lps5_pstate", pstate_o, 4);
      check("lps5_valmps", valmps_o, 1);
      check("lps5_range", dut.range_reg, 370);
      check("lps5_offset", dut.offset_reg, 373);

      // Bypass (reserved mode 3) producing a one
      do_start();
      send_byte(8'h7F);
      send_byte(8'hFF);
      check("byp1_init_offset", dut.offset_reg, 255);
      bin_req(2'd0, 6'd0, 1'b0);
      check("byp1_pre_range", dut.range_reg, 270);
      bin_req(2'd3, 6'd17, 1'b1);
      check("byp1_bin", bin_o, 1);
      check("byp1_offset", dut.offset_reg, 241);
      check("byp1_range", dut.range_reg, 270);
      check("byp1_pstate_echo", pstate_o, 17);
      check("byp1_valmps_echo", valmps_o, 1);

      // Bypass, starvation, refill, terminate (bin 0)
      do_start();
      send_byte(8'h00);
      send_byte(8'h00);
      bin_req(2'd1, 6'd0, 1'b0);
      check("byp0_bin", bin_o, 0);
      check("byp0_offset", dut.offset_reg, 0);
      check("starve_count", dut.cnt_reg, 6);
      check("starve_ready_low", bin_ready_o, 0);
      send_byte(8'h00);
      check("refill_ready", bin_ready_o, 1);
      check("refill_count", dut.cnt_reg, 14);
      bin_req(2'd2, 6'd0, 1'b0);
      check("term0_bin", bin_o, 0);
      check("term0_range", dut.range_reg, 508);
      check("term0_count", dut.cnt_reg, 14);

      // Terminate (bin 1) ends the slice
      do_start();
      send_byte(8'hFF);
      send_byte(8'hFF);
      bin_req(2'd2, 6'd0, 1'b0);
      check("term1_valid", bin_valid_o, 1);
      check("term1_bin", bin_o, 1);
      check("term1_count", dut.cnt_reg, 7);
      check("term1_idle_ready", bin_ready_o, 0);
      bin_req(2'd1, 6'd0, 1'b0);
      check("term1_no_bin_in_idle", bin_valid_o, 0);

      // Restart beats simultaneous bin and byte
      do_start();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      bin_req(2'd1, 6'd0, 1'b0);
      check("pre_restart_count", dut.cnt_reg, 14);
      start_i = 1'b1; bin_valid_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hA5;
      #1;
      check("restart_byte_ready", byte_ready_o, 0);
      check("restart_bin_ready", bin_ready_o, 0);
      step();
      start_i = 1'b0; bin_valid_i = 1'b0; byte_valid_i = 1'b0;
      check("restart_no_bin", bin_valid_o, 0);
      check("restart_count", dut.cnt_reg, 0);
`ifdef CABAC_DEC_BIN_CNT_EN
      check("restart_bin_cnt", bin_cnt_o, 0);
`endif

      // Reset in the middle of a bin stream
      send_byte(8'h00);
      send_byte(8'h00);
      bin_req(2'd0, 6'd10, 1'b1);
      check("prerst_pstate", pstate_o, 11);
      bin_valid_i = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0; bin_valid_i = 1'b0;
      check("midrst_bin_valid", bin_valid_o, 0);
      check("midrst_bin", bin_o, 0);
      check("midrst_pstate", pstate_o, 0);
      check("midrst_valmps", valmps_o, 0);
      check("midrst_byte_ready", byte_ready_o, 1);
      check("midrst_bin_ready", bin_ready_o, 0);
      check("midrst_range", dut.range_reg, 510);
      check("midrst_count", dut.cnt_reg, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
